// File: rtl/morphle_pkg.sv
// Shared tokens, channel states and helpers for the Morphle
// yellow-cell match row.
package morphle_pkg;

  typedef logic [1:0] tok_t;

  localparam tok_t VEMPTY = 2'd0;
  localparam tok_t V0     = 2'd1;
  localparam tok_t V1     = 2'd2;

  typedef enum logic [2:0] {
    EMPTY,
    GOT_IN,
    GOT_MATCH,
    FULL,
    DRAIN_IN,
    DRAIN_MATCH
  } ch_state_e;

  function automatic logic tok_valid(input tok_t t);
    return (t == V0) || (t == V1);
  endfunction

  function automatic logic is_fired(input ch_state_e s);
    return (s == FULL) || (s == DRAIN_IN) ||
           (s == DRAIN_MATCH);
  endfunction

endpackage

// File: rtl/ycsync_ch.sv
// One yellow-cell match channel: input synchroniser, RTZ FSM, out reg.
// Error events exist only with YCROW_ILLEGAL_DETECT_EN defined.
module ycsync_ch
  import morphle_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] in,
  input  logic [1:0] match,
  output logic [1:0] out,
`ifdef YCROW_ILLEGAL_DETECT_EN
  output logic       err_ev,
`endif
  output logic       fire_nxt
);

  tok_t s_in;
  tok_t s_match;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign s_in    = in;
      assign s_match = match;
    end else begin : g_sync
      tok_t q_in [SYNC_STAGES];
      tok_t q_m  [SYNC_STAGES];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            q_in[i] <= VEMPTY;
            q_m[i]  <= VEMPTY;
          end
        end else begin
          q_in[0] <= in;
          q_m[0]  <= match;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            q_in[i] <= q_in[i-1];
            q_m[i]  <= q_m[i-1];
          end
        end
      end

      assign s_in    = q_in[SYNC_STAGES-1];
      assign s_match = q_m[SYNC_STAGES-1];
    end
  endgenerate

  ch_state_e st, st_nxt;
  tok_t      lin, lin_nxt;
  tok_t      lm, lm_nxt;
  tok_t      out_nxt;
  logic      vi, vm;

  assign vi = tok_valid(s_in);
  assign vm = tok_valid(s_match);

  always_comb begin
    st_nxt  = st;
    lin_nxt = lin;
    lm_nxt  = lm;
    unique case (st)
      EMPTY: begin
        if (vi) lin_nxt = s_in;
        if (vm) lm_nxt  = s_match;
        if (vi && vm)  st_nxt = FULL;
        else if (vi)   st_nxt = GOT_IN;
        else if (vm)   st_nxt = GOT_MATCH;
      end
      GOT_IN: begin
        if (!vi) begin
          st_nxt  = EMPTY;
          lin_nxt = VEMPTY;
        end else if (vm) begin
          st_nxt = FULL;
          lm_nxt = s_match;
        end
      end
      GOT_MATCH: begin
        if (!vm) begin
          st_nxt = EMPTY;
          lm_nxt = VEMPTY;
        end else if (vi) begin
          st_nxt  = FULL;
          lin_nxt = s_in;
        end
      end
      FULL: begin
        if (!vi && !vm) begin
          st_nxt  = EMPTY;
          lin_nxt = VEMPTY;
          lm_nxt  = VEMPTY;
        end else if (!vm) begin
          st_nxt = DRAIN_IN;
        end else if (!vi) begin
          st_nxt = DRAIN_MATCH;
        end
      end
      DRAIN_IN: begin
        if (!vi) begin
          st_nxt  = EMPTY;
          lin_nxt = VEMPTY;
          lm_nxt  = VEMPTY;
        end
      end
      DRAIN_MATCH: begin
        if (!vm) begin
          st_nxt  = EMPTY;
          lin_nxt = VEMPTY;
          lm_nxt  = VEMPTY;
        end
      end
      default: begin
        st_nxt  = EMPTY;
        lin_nxt = VEMPTY;
        lm_nxt  = VEMPTY;
      end
    endcase
  end

  // out is registered from next-state so it lands with the state.
  assign fire_nxt = is_fired(st_nxt);

  always_comb begin
    out_nxt = VEMPTY;
    if (fire_nxt)
      out_nxt = (lin_nxt == V1 && lm_nxt == V1) ? V1 : V0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st  <= EMPTY;
      lin <= VEMPTY;
      lm  <= VEMPTY;
      out <= VEMPTY;
    end else begin
      st  <= st_nxt;
      lin <= lin_nxt;
      lm  <= lm_nxt;
      out <= out_nxt;
    end
  end

`ifdef YCROW_ILLEGAL_DETECT_EN
  logic chg_in, chg_m;

  assign chg_in = vi && (s_in != lin);
  assign chg_m  = vm && (s_match != lm);

  always_comb begin
    err_ev = (s_in == 2'd3) || (s_match == 2'd3);
    unique case (st)
      GOT_IN:      err_ev = err_ev | chg_in;
      GOT_MATCH:   err_ev = err_ev | chg_m;
      FULL:        err_ev = err_ev | chg_in | chg_m;
      DRAIN_IN:    err_ev = err_ev | vm | chg_in;
      DRAIN_MATCH: err_ev = err_ev | vi | chg_m;
      default:     err_ev = err_ev;
    endcase
  end
`endif

endmodule

// File: rtl/ycrow_sync.sv
// Row of CHANNELS yellow-cell match channels with done/err flags.
// Optional: YCROW_ILLEGAL_DETECT_EN enables the sticky err flag.
module ycrow_sync
  import morphle_pkg::*;
#(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2*CHANNELS-1:0] in,
  input  logic [2*CHANNELS-1:0] match,
  output logic [2*CHANNELS-1:0] out,
  output logic                  done,
  output logic                  err
);

  logic [CHANNELS-1:0] fire_nxt;
`ifdef YCROW_ILLEGAL_DETECT_EN
  logic [CHANNELS-1:0] err_ev;
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    ycsync_ch #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .in      (in[2*k +: 2]),
      .match   (match[2*k +: 2]),
      .out     (out[2*k +: 2]),
`ifdef YCROW_ILLEGAL_DETECT_EN
      .err_ev  (err_ev[k]),
`endif
      .fire_nxt(fire_nxt[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done <= 1'b0;
    else          done <= &fire_nxt;
  end

`ifdef YCROW_ILLEGAL_DETECT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else          err <= err | (|err_ev);
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ycrow_sync.sv
// Directed bench for ycrow_sync: 8-channel and 1-channel rows.
module tb_ycrow_sync;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in8 = '0;
  logic [15:0] m8 = '0;
  logic [15:0] out8;
  logic        done8, err8;
  logic [1:0]  in1 = '0;
  logic [1:0]  m1 = '0;
  logic [1:0]  out1;
  logic        done1, err1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ycrow_sync #(.CHANNELS(8), .SYNC_STAGES(2)) u8 (
    .clk(clk), .reset_n(reset_n), .in(in8), .match(m8),
    .out(out8), .done(done8), .err(err8)
  );

  ycrow_sync #(.CHANNELS(1), .SYNC_STAGES(2)) u1 (
    .clk(clk), .reset_n(reset_n), .in(in1), .match(m1),
    .out(out1), .done(done1), .err(err1)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic exp_err;

  initial begin
`ifdef YCROW_ILLEGAL_DETECT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    #12;
    chk("rst_out8", out8, 16'h0);
    chk("rst_done8", {15'd0, done8}, 16'd0);
    chk("rst_err8", {15'd0, err8}, 16'd0);
    chk("rst_out1", {14'd0, out1}, 16'd0);
    chk("rst_done1", {15'd0, done1}, 16'd0);
    reset_n = 1'b1;
    step(2);

    // same-cycle V1/V1 pair
    in1 = 2'd2; m1 = 2'd2;
    in8[1:0] = 2'd2; m8[1:0] = 2'd2;
    step(2);
    chk("lat_early", {14'd0, out1}, 16'd0);
    chk("lat_done_early", {15'd0, done1}, 16'd0);
    step(1);
    chk("lat_out1", {14'd0, out1}, 16'd2);
    chk("lat_done1", {15'd0, done1}, 16'd1);
    chk("lat_out8", out8, 16'h0002);
    chk("lat_done8", {15'd0, done8}, 16'd0);
    in1 = 2'd0; m1 = 2'd0;
    in8 = '0; m8 = '0;
    step(3);
    chk("rtz_out1", {14'd0, out1}, 16'd0);
    chk("rtz_done1", {15'd0, done1}, 16'd0);
    chk("rtz_out8", out8, 16'h0);

    // V0 first, V1 match later, then drain
    in8[1:0] = 2'd1;
    step(5);
    m8[1:0] = 2'd2;
    step(2);
    chk("v0_early", out8, 16'h0);
    step(1);
    chk("v0_fire", out8, 16'h0001);
    in8[1:0] = 2'd2;
    step(3);
    chk("v0_nochg", out8, 16'h0001);
    m8[1:0] = 2'd0;
    step(3);
    chk("drain_in_hold", out8, 16'h0001);
    in8[1:0] = 2'd0;
    step(2);
    chk("drain_in_late", out8, 16'h0001);
    step(1);
    chk("drain_in_rtz", out8, 16'h0);

    // re-assert during DRAIN_MATCH
    in8[1:0] = 2'd1; m8[1:0] = 2'd2;
    step(3);
    chk("dm_fire", out8, 16'h0001);
    in8[1:0] = 2'd0;
    step(3);
    chk("dm_hold", out8, 16'h0001);
    in8[1:0] = 2'd2;
    step(3);
    chk("dm_reassert", out8, 16'h0001);
    m8[1:0] = 2'd0;
    step(3);
    chk("dm_rtz", out8, 16'h0);
    in8[1:0] = 2'd0;
    step(3);
    in8[1:0] = 2'd2; m8[1:0] = 2'd2;
    step(3);
    chk("dm_fresh", out8, 16'h0002);
    in8 = '0; m8 = '0;
    step(3);
    chk("dm_clear", out8, 16'h0);

    // done over 8 channels
    in8 = 16'hA2AA; m8 = 16'hAAAA;
    step(3);
    chk("done_miss5", {15'd0, done8}, 16'd0);
    chk("out_miss5", out8, 16'hA2AA);
    in8 = 16'hAAAA;
    step(2);
    chk("done_early", {15'd0, done8}, 16'd0);
    step(1);
    chk("done_all", {15'd0, done8}, 16'd1);
    chk("out_all", out8, 16'hAAAA);
    in8 = 16'hAA2A; m8 = 16'hAA2A;
    step(2);
    chk("done_hold", {15'd0, done8}, 16'd1);
    step(1);
    chk("done_drop", {15'd0, done8}, 16'd0);
    in8 = '0; m8 = '0;
    step(3);

    // illegal code 3 on channel 2 match
    m8[5:4] = 2'd3;
    step(3);
    chk("ill_err", {15'd0, err8}, {15'd0, exp_err});
    chk("ill_out", out8, 16'h0);
    m8[5:4] = 2'd0;
    step(3);
    chk("ill_err_sticky", {15'd0, err8}, {15'd0, exp_err});
    in8[5:4] = 2'd1; m8[5:4] = 2'd1;
    step(3);
    chk("ill_after", out8, 16'h0010);
    in8 = '0; m8 = '0;
    step(3);

    // asynchronous reset mid-token
    in1 = 2'd2; m1 = 2'd2;
    in8[1:0] = 2'd2; m8[1:0] = 2'd2;
    step(3);
    chk("ar_pre_out1", {14'd0, out1}, 16'd2);
    chk("ar_pre_done1", {15'd0, done1}, 16'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_out1", {14'd0, out1}, 16'd0);
    chk("ar_done1", {15'd0, done1}, 16'd0);
    chk("ar_out8", out8, 16'h0);
    chk("ar_err8", {15'd0, err8}, 16'd0);
    in1 = '0; m1 = '0;
    in8 = '0; m8 = '0;
    #3;
    reset_n = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
